// File: rtl/scan_seq3.sv
// scan_seq3: step-rate scan sequencer producing a 3-bit select index with endpoint pulses.
module scan_seq3 #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       A,
  output logic             busy,
  output logic             wrap
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [1:0] mode_q;
  logic [DIV_W-1:0] div_q, cnt;
  logic dir, launch, tick, halt, down;
  logic [2:0] a_step;
  logic dir_step, wrap_step;
  assign launch = state == IDLE && start && !stop;
  assign tick = state == RUN && cnt == div_q;
  // one-shot mode ends on the tick that would move past 7
  assign halt = tick && mode_q == 2'b11 && A == 3'd7;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (launch ? RUN : IDLE) : ((stop || halt) ? IDLE : RUN);
  always_comb begin
    busy = state == RUN;
    down = mode_q == 2'b01 || (mode_q == 2'b10 && !dir);
    a_step = down ? A - 3'd1 : A + 3'd1;
    dir_step = mode_q == 2'b10 ? (a_step == 3'd7 ? 1'b0 : a_step == 3'd0 ? 1'b1 : dir) : dir;
    wrap_step = mode_q == 2'b00 ? a_step == 3'd0 :
                mode_q == 2'b10 ? (a_step == 3'd0 || a_step == 3'd7) : a_step == 3'd7;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      A <= 3'd0;
      wrap <= 1'b0;
      cnt <= '0;
      dir <= 1'b1;
      mode_q <= 2'b00;
      div_q <= '0;
    end else begin
      wrap <= 1'b0;
      if (launch) begin
        mode_q <= mode;
        div_q <= div;
        cnt <= '0;
        A <= mode == 2'b01 ? 3'd7 : 3'd0;
        dir <= 1'b1;
      end else if (state == RUN) begin
        cnt <= (stop || tick) ? '0 : cnt + 1'b1;
        if (tick && !stop && !halt) begin
          A <= a_step;
          dir <= dir_step;
          wrap <= wrap_step;
        end
      end
    end
endmodule

// File: doc/scan_seq3.md
SCAN_SEQ3 -- requirements
Module: scan_seq3

Interface
REQ-001 Parameter: DIV_W, default 8, width of the step-rate divider input and internal prescaler.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  level sampled each cycle; a high sample in IDLE begins a scan.
REQ-005 Port: stop  input  1  level sampled each cycle; a high sample in RUN aborts the scan.
REQ-006 Port: mode  input  2  scan pattern: 00 up-wrap, 01 down-wrap, 10 bounce, 11 one-shot up.
REQ-007 Port: div  input  DIV_W  step period minus one, in clk cycles.
REQ-008 Port: A  output  3  registered select index, drives A[2:0] of the downstream dec3x8.
REQ-009 Port: busy  output  1  high while the state machine is in RUN.
REQ-010 Port: wrap  output  1  one-cycle pulse marking an endpoint event, defined below.

Function
REQ-011 States: IDLE and RUN only, held in registers; busy SHALL equal (state == RUN).
REQ-012 IDLE to RUN: when start=1 and stop=0 in IDLE, the next edge latches mode and div, clears the prescaler, and loads A (7 for mode 01, else 0); direction flag set to up.
REQ-013 Latched mode/div SHALL govern the whole scan; input changes during RUN are ignored.
REQ-014 start while in RUN SHALL be ignored (no restart, no reload).
REQ-015 RUN to IDLE on stop: stop=1 in RUN returns to IDLE at the next edge; A holds its current value; the prescaler clears; no step occurs on that edge even if a tick coincides.
REQ-016 start and stop both high: stop wins; in IDLE nothing happens, in RUN REQ-015 applies.
REQ-017 Prescaler: DIV_W-bit counter in RUN; tick when count == latched div, counter then returns to 0, else increments; div=0 yields a tick every cycle.
REQ-018 First step SHALL occur div+1 cycles after the edge entering RUN; steps then every div+1 cycles.
REQ-019 On each tick, A updates per latched mode: 00 A+1 mod 8 (7->0); 01 A-1 mod 8 (0->7).
REQ-020 Mode 10: counts up to 7, then down to 0, then up, and so on (0,1..7,6..0,1..); direction flips on the step that reaches an endpoint; no endpoint value is repeated.
REQ-021 Mode 11: counts 0..7; the tick occurring with A==7 SHALL move to IDLE with A held at 7 and no further step.
REQ-022 wrap SHALL be high for exactly the one cycle following the edge that loads the new A value when: mode 00 A becomes 0; mode 01 A becomes 7; mode 10 A becomes 7 or 0; mode 11 A becomes 7. No wrap on the initial load in REQ-012.
REQ-023 All outputs are registered; no combinational path from any input to A or wrap.

Reset
REQ-024 rst_n low SHALL immediately, without clk, force state IDLE, A=0, busy=0, wrap=0, prescaler=0, direction up, latched mode=00, latched div=0.
REQ-025 Reset asserted mid-scan SHALL abort with the REQ-024 values; after release the block stays in IDLE until start is sampled.

Verification
REQ-026 rst_n low 3 cycles, then start=1 one cycle, mode=00, div=0 -> A steps 0,1,..,7,0 once per cycle; wrap high only in the cycle A shows 0 again; busy=1 throughout.
REQ-027 mode=01, div=2, start pulse -> A loads 7, then 6,5,.. changing every 3 cycles; after 7 steps A=0, next step A=7 with wrap pulse.
REQ-028 mode=10, div=0 -> A sequence 0,1,..,7,6,..,0,1; wrap pulses at the cycles showing 7 and 0 only.
REQ-029 mode=11, div=1 -> A 0..7 every 2 cycles, wrap when A=7, busy drops 2 cycles later, A stays 7; a later start reloads A=0.
REQ-030 mode=00, div=3, stop=1 for one cycle while A=4 and a tick coincides -> busy=0 next cycle, A stays 4; start+stop together in IDLE -> no change.
REQ-031 Async reset asserted between clock edges while A=5 in RUN -> A=0, busy=0 before the next edge; mode/div changed during RUN verified to have no effect until next start.
